zl_rst_seq: RTL and testbench



---
 rtl/zl_rst_seq_pkg.sv | 30 +++
 rtl/zl_sync_ff.sv | 25 ++
 rtl/zl_rst_seq.sv | 166 ++++++++++++++++
 tb/tb_zl_rst_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/zl_rst_seq_pkg.sv
// zl_rst_seq shared package: FSM state encodings, default
// parameter values and a small elaboration-time helper.
package zl_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_STABLE = 3'd1,
        S_CORE   = 3'd2,
        S_RUN    = 3'd3,
        S_SWRST  = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_DP_DELAY_CYCLES    = 16;
    localparam int DEF_SW_RST_CYCLES      = 8;

    localparam int LOSS_CNT_W   = 8;
    localparam int LOSS_CNT_MAX = 255;

    // Largest of three counts, used to size the shared sequencing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/zl_sync_ff.sv
// zl_sync_ff: N-stage single-bit synchronizer, async active-low
// reset to 0. Generic building block for any async level input.
module zl_sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    // Shift the async input through N flops; MSB is the safe output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/zl_rst_seq.sv
// zl_rst_seq: PLL-lock driven staged reset sequencer (core, then datapath).
// Define ZL_RST_SEQ_LOCK_LOSS_CNT_EN to enable the lock-loss event counter.
module zl_rst_seq
    import zl_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int DP_DELAY_CYCLES    = DEF_DP_DELAY_CYCLES,
    parameter int SW_RST_CYCLES      = DEF_SW_RST_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  sw_rst,
    output logic                  rst_core_n,
    output logic                  rst_dp_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_CYC = max3(LOCK_STABLE_CYCLES,
                                  DP_DELAY_CYCLES,
                                  SW_RST_CYCLES);
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] C_LOCK = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] C_DP   = CW'(DP_DELAY_CYCLES);
    localparam logic [CW-1:0] C_SW   = CW'(SW_RST_CYCLES);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          w_lock_s;
    logic [CW-1:0] w_cnt_inc;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_core_n;
    logic          r_dp_n;
    logic          r_ready;

    zl_sync_ff #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_cnt_inc = r_cnt + C_ONE;

    // Sequencing FSM; every reset output is a flop driven from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HOLD;
            r_cnt    <= '0;
            r_core_n <= 1'b0;
            r_dp_n   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_core_n <= 1'b0;
                    r_dp_n   <= 1'b0;
                    r_ready  <= 1'b0;
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= C_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc >= C_LOCK) begin
                        r_state  <= S_CORE;
                        r_cnt    <= '0;
                        r_core_n <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_CORE: begin
                    if (!w_lock_s) begin
                        r_state  <= S_HOLD;
                        r_cnt    <= '0;
                        r_core_n <= 1'b0;
                        r_dp_n   <= 1'b0;
                        r_ready  <= 1'b0;
                    end else if (w_cnt_inc >= C_DP) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_dp_n  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        r_state  <= S_HOLD;
                        r_cnt    <= '0;
                        r_core_n <= 1'b0;
                        r_dp_n   <= 1'b0;
                        r_ready  <= 1'b0;
                    end else if (sw_rst) begin
                        r_state  <= S_SWRST;
                        r_cnt    <= '0;
                        r_core_n <= 1'b0;
                        r_dp_n   <= 1'b0;
                        r_ready  <= 1'b0;
                    end
                end
                S_SWRST: begin
                    if (!w_lock_s) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc >= C_SW) begin
                        // Lock is still good: skip re-qualification.
                        r_state  <= S_CORE;
                        r_cnt    <= '0;
                        r_core_n <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state  <= S_HOLD;
                    r_cnt    <= '0;
                    r_core_n <= 1'b0;
                    r_dp_n   <= 1'b0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_core_n = r_core_n;
    assign rst_dp_n   = r_dp_n;
    assign ready      = r_ready;

`ifdef ZL_RST_SEQ_LOCK_LOSS_CNT_EN
    localparam logic [LOSS_CNT_W-1:0] C_LOSS_MAX = LOSS_CNT_W'(LOSS_CNT_MAX);

    logic                  w_loss;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // Only a lock drop seen while fully running is a lock-loss event.
    assign w_loss = (r_state == S_RUN) && !w_lock_s;

    // Saturating lock-loss event counter, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != C_LOSS_MAX)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_zl_rst_seq.sv
// tb_zl_rst_seq: directed table-driven bench for zl_rst_seq
// plus hand-written multi-cycle sequences.
module tb_zl_rst_seq;

    typedef struct {
        logic pll;
        logic sw;
        logic core;
        logic dp;
        logic rdy;
    } vec_t;

`ifdef ZL_RST_SEQ_LOCK_LOSS_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       sw_rst;
    logic       rst_core_n;
    logic       rst_dp_n;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int n_chk;
    int n_err;
    vec_t vq[$];

    zl_rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .DP_DELAY_CYCLES    (4),
        .SW_RST_CYCLES      (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .sw_rst        (sw_rst),
        .rst_core_n    (rst_core_n),
        .rst_dp_n      (rst_dp_n),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic c,
                           input logic d, input logic r);
        chk({nm, ".core"}, {7'd0, rst_core_n}, {7'd0, c});
        chk({nm, ".dp"}, {7'd0, rst_dp_n}, {7'd0, d});
        chk({nm, ".ready"}, {7'd0, ready}, {7'd0, r});
    endtask

    task automatic add(input logic p, input logic s, input logic c,
                       input logic d, input logic r, input int n);
        vec_t v;
        v.pll = p; v.sw = s; v.core = c; v.dp = d; v.rdy = r;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    initial begin
        int lim;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        pll_lock = 1'b0;
        sw_rst = 1'b0;

        // lock-up: core on 10th edge, datapath 4 edges later
        add(1, 0, 0, 0, 0, 9);
        add(1, 0, 1, 0, 0, 4);
        add(1, 0, 1, 1, 1, 3);
        // software reset in RUN
        add(1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 2);
        add(1, 0, 1, 0, 0, 4);
        add(1, 0, 1, 1, 1, 2);
        // lock loss in RUN: drop seen on third edge
        add(0, 0, 1, 1, 1, 2);
        add(0, 0, 0, 0, 0, 3);
        // glitchy lock: 5 high, 1 low, then 8 fresh cycles needed
        add(1, 0, 0, 0, 0, 5);
        add(0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 9);
        add(1, 0, 1, 0, 0, 4);
        add(1, 0, 1, 1, 1, 1);

        step();
        step();
        chk_out("reset", 0, 0, 0);
        chk("reset.cnt", lock_loss_cnt, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            pll_lock = vq[i].pll;
            sw_rst = vq[i].sw;
            step();
            chk_out($sformatf("row%0d", i),
                    vq[i].core, vq[i].dp, vq[i].rdy);
        end
        sw_rst = 1'b0;
        chk("loss1.cnt", lock_loss_cnt, 8'(CNT_EN));

        // second lock loss
        pll_lock = 1'b0;
        step();
        step();
        chk_out("loss2.pre", 1, 1, 1);
        step();
        chk_out("loss2", 0, 0, 0);
        chk("loss2.cnt", lock_loss_cnt, 8'(2 * CNT_EN));

        // sw_rst while in S_STABLE is ignored
        pll_lock = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk_out("swstable.e5", 0, 0, 0);
        for (int k = 6; k <= 9; k++) step();
        chk_out("swstable.e9", 0, 0, 0);
        step();
        chk_out("swstable.e10", 1, 0, 0);
        step();
        chk_out("core.pre", 1, 0, 0);

        // async reset in S_CORE, no clock edge
        rst_n = 1'b0;
        #1;
        chk_out("async", 0, 0, 0);
        chk("async.cnt", lock_loss_cnt, 8'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        chk_out("rerun.e9", 0, 0, 0);
        step();
        chk_out("rerun.e10", 1, 0, 0);
        for (int k = 11; k <= 13; k++) step();
        chk_out("rerun.e13", 1, 0, 0);
        step();
        chk_out("rerun.e14", 1, 1, 1);

`ifdef ZL_RST_SEQ_LOCK_LOSS_CNT_EN
        // saturation after 260 lock-loss events
        for (int e = 0; e < 260; e++) begin
            pll_lock = 1'b0;
            step();
            step();
            step();
            pll_lock = 1'b1;
            lim = 0;
            while (!ready && lim < 40) begin
                step();
                lim++;
            end
            if (lim >= 40) begin
                chk("sat.timeout", {7'd0, ready}, 8'd1);
                break;
            end
        end
        chk("sat.cnt", lock_loss_cnt, 8'd255);
`else
        lim = 0;
        chk("nocnt", lock_loss_cnt, 8'(lim));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
